// File: rtl/fetch_stage_mw.sv
// fetch_stage_mw: multi-wide fetch stage between instruction memory and the
// instruction buffer.
//   - Issues group requests (N words from mem_req_addr) and keeps up to DEPTH
//     requests in flight. A credit covers an accepted request until its group
//     has been fully delivered or its stale beat has been dropped.
//   - Buffers in-order response beats in a DEPTH-entry FIFO and drains the
//     head entry into the instruction buffer, up to ib_spots words per cycle.
//     A single cycle never merges words from two entries.
//   - restore_valid redirects the PC, flushes the FIFO and arranges for every
//     response still in flight to be discarded when it arrives.
// Ports:
//   clock, reset (async, active low)
//   mem_req_valid/ready/addr   request channel to instruction memory
//   mem_rsp_valid/inst         response beat (no back-pressure, in order)
//   restore_valid/PC_restore   redirect
//   ib_spots                   free buffer entries this cycle
//   ib_count/inst/pc/taken     delivered words, oldest in slot 0

// One delivery slot: picks word head_off+LANE of the head entry and its PC.
// Slots at or beyond ib_count are driven to zero.
module fetch_slot #(
   parameter int N    = 4,
   parameter int XLEN = 32,
   parameter int NW   = 3,
   parameter int LANE = 0
) (
   input  logic [N-1:0][31:0] words,
   input  logic [XLEN-1:0]    base,
   input  logic [NW-1:0]      head_off,
   input  logic [NW-1:0]      count,
   output logic [31:0]        inst,
   output logic [XLEN-1:0]    pc
);
   logic [NW:0] idx;

   always_comb begin
      idx  = {1'b0, head_off} + (NW+1)'(LANE);
      inst = '0;
      pc   = '0;
      if (NW'(LANE) < count) begin
         for (int j = 0; j < N; j++)
            if (idx == (NW+1)'(j)) inst = words[j];
         pc = base + XLEN'({idx, 2'b00});
      end
   end
endmodule

module fetch_stage_mw #(
   parameter int              N        = 4,
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic [XLEN-1:0]           mem_req_addr,
   input  logic                      mem_rsp_valid,
   input  logic [N-1:0][31:0]        mem_rsp_inst,
   input  logic                      restore_valid,
   input  logic [XLEN-1:0]           PC_restore,
   input  logic [$clog2(N+1)-1:0]    ib_spots,
   output logic [$clog2(N+1)-1:0]    ib_count,
   output logic [N-1:0][31:0]        ib_inst,
   output logic [N-1:0][XLEN-1:0]    ib_pc,
   output logic [N-1:0]              ib_taken
);
   localparam int NW = $clog2(N+1);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [N-1:0][31:0] words;
      logic [XLEN-1:0]    base;
   } entry_t;

   entry_t          fifo [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   occ, outstanding, drop_cnt;
   logic [XLEN-1:0] fetch_pc;
   // PC of the oldest live (non-stale) request; the base of the next pushed beat.
   logic [XLEN-1:0] live_pc;
   logic [NW-1:0]   head_off, avail;
   logic            req_fire, push, pop;

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign head     = fifo[rd_ptr];
   assign avail    = NW'(N) - head_off;
   assign ib_taken = '0;

   always_comb begin
      mem_req_valid = reset && !restore_valid &&
                      (({1'b0, outstanding} + {1'b0, occ}) < (CW+1)'(DEPTH));
      mem_req_addr  = fetch_pc;
      req_fire      = mem_req_valid && mem_req_ready;
      push          = mem_rsp_valid && !restore_valid && (drop_cnt == '0);
      ib_count      = '0;
      if (reset && occ != '0 && !restore_valid)
         ib_count = (ib_spots < avail) ? ib_spots : avail;
      // head_off + ib_count never exceeds N, so it fits in NW bits
      pop           = (ib_count != '0) && ((head_off + ib_count) == NW'(N));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_pc    <= RESET_PC;
         live_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         head_off    <= '0;
      end else begin
         // stale beats keep their credit until they actually return
         outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
         if (restore_valid) begin
            fetch_pc <= PC_restore;
            live_pc  <= PC_restore;
            drop_cnt <= outstanding - CW'(mem_rsp_valid);
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            head_off <= '0;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4*N);
            if (mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            if (push) begin
               wr_ptr  <= inc_ptr(wr_ptr);
               live_pc <= live_pc + XLEN'(4*N);
            end
            if (pop) begin
               rd_ptr   <= inc_ptr(rd_ptr);
               head_off <= '0;
            end else begin
               head_off <= head_off + ib_count;
            end
            occ <= occ + CW'(push) - CW'(pop);
         end
      end
   end

   // entry payload needs no reset: it is only read while occ != 0
   always_ff @(posedge clock)
      if (push) fifo[wr_ptr] <= '{words: mem_rsp_inst, base: live_pc};

   // credit accounting makes a push into a full FIFO impossible
   assert property (@(posedge clock) disable iff (!reset)
                    !(push && occ == CW'(DEPTH)));

   for (genvar i = 0; i < N; i++) begin : g_slot
      fetch_slot #(.N(N), .XLEN(XLEN), .NW(NW), .LANE(i)) u_slot (
         .words    (head.words),
         .base     (head.base),
         .head_off (head_off),
         .count    (ib_count),
         .inst     (ib_inst[i]),
         .pc       (ib_pc[i])
      );
   end
endmodule

// File: tb/tb_fetch_stage_mw.sv
// Bench for fetch_stage_mw: an in-order memory model with programmable
// latency, a scoreboard of expected {pc, word} pairs filled when live beats
// are returned, and directed cycle-by-cycle checks of the handshake.
module tb_fetch_stage_mw;
   localparam int N = 4, XLEN = 32, DEPTH = 2;
   localparam int NW = $clog2(N+1);

   logic                   clock = 0, reset = 1;
   logic                   mem_req_valid, mem_req_ready = 0;
   logic [XLEN-1:0]        mem_req_addr;
   logic                   mem_rsp_valid = 0;
   logic [N-1:0][31:0]     mem_rsp_inst = '0;
   logic                   restore_valid = 0;
   logic [XLEN-1:0]        PC_restore = '0;
   logic [NW-1:0]          ib_spots = '0;
   logic [NW-1:0]          ib_count;
   logic [N-1:0][31:0]     ib_inst;
   logic [N-1:0][XLEN-1:0] ib_pc;
   logic [N-1:0]           ib_taken;

   always #5 clock = ~clock;

   fetch_stage_mw #(.N(N), .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clock(clock), .reset(reset),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_inst(mem_rsp_inst),
      .restore_valid(restore_valid), .PC_restore(PC_restore),
      .ib_spots(ib_spots), .ib_count(ib_count), .ib_inst(ib_inst), .ib_pc(ib_pc), .ib_taken(ib_taken)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

   mreq_t mq[$];
   exp_t  sb[$];
   int cyc = 0, lat = 1, stale_left = 0;
   int vectors = 0, miscompares = 0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // memory: returns the oldest accepted request once its latency has elapsed
   always @(posedge clock) begin
      #1;
      cyc++;
      mem_rsp_valid = 0;
      mem_rsp_inst  = '0;
      if (reset && mq.size() > 0 && mq[0].due <= cyc) begin
         mem_rsp_valid = 1;
         for (int i = 0; i < N; i++) mem_rsp_inst[i] = word_at(mq[0].addr + 32'(4*i));
      end
   end

   // monitor: compare deliveries, then update memory / scoreboard state
   always @(negedge clock) begin : mon
      exp_t  e;
      mreq_t m;
      if (!reset) begin
         mq.delete();
         sb.delete();
         stale_left = 0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (i < int'(ib_count)) begin
               if (sb.size() == 0) begin
                  chk($sformatf("unexpected_slot%0d_pc", i), 64'(ib_pc[i]), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  e = sb.pop_front();
                  chk($sformatf("slot%0d_pc", i), 64'(ib_pc[i]), 64'(e.pc));
                  chk($sformatf("slot%0d_inst", i), 64'(ib_inst[i]), 64'(e.inst));
               end
            end else begin
               chk($sformatf("idle_slot%0d", i), {ib_pc[i], ib_inst[i]}, 64'h0);
            end
         end
         chk("ib_taken", 64'(ib_taken), 64'h0);
         if (restore_valid) begin
            stale_left = mq.size();
            sb.delete();
         end
         if (mem_rsp_valid && mq.size() > 0) begin
            m = mq.pop_front();
            if (stale_left > 0) stale_left--;
            else for (int i = 0; i < N; i++)
               sb.push_back('{m.addr + 32'(4*i), word_at(m.addr + 32'(4*i))});
         end
         if (mem_req_valid && mem_req_ready) mq.push_back('{mem_req_addr, cyc + lat});
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // reset, then release with the given buffer space and memory latency;
   // returns at the start of cycle C0
   task automatic start(input int spots, input int l);
      tick();
      reset = 0; restore_valid = 0; mem_req_ready = 0; ib_spots = '0;
      tick();
      lat = l; ib_spots = NW'(spots); mem_req_ready = 1; reset = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "timeout");
   end

   initial begin
      #2 reset = 0;
      @(negedge clock);
      chk("rst_req_valid", 64'(mem_req_valid), 0);
      chk("rst_req_addr",  64'(mem_req_addr), 0);
      chk("rst_ib_count",  64'(ib_count), 0);
      for (int i = 0; i < N; i++) chk($sformatf("rst_slot%0d", i), {ib_pc[i], ib_inst[i]}, 0);

      // full-width streaming, 1-cycle memory
      start(4, 1);
      @(negedge clock); chk("t1_c0_valid", 64'(mem_req_valid), 1); chk("t1_c0_addr", 64'(mem_req_addr), 0);
      tick(); @(negedge clock); chk("t1_c1_valid", 64'(mem_req_valid), 1); chk("t1_c1_addr", 64'(mem_req_addr), 32'h10);
      tick(); @(negedge clock);
      chk("t1_c2_count", 64'(ib_count), 4); chk("t1_c2_pc0", 64'(ib_pc[0]), 0);
      chk("t1_c2_pc3", 64'(ib_pc[3]), 32'hC); chk("t1_c2_valid", 64'(mem_req_valid), 0);
      tick(); @(negedge clock);
      chk("t1_c3_addr", 64'(mem_req_addr), 32'h20); chk("t1_c3_valid", 64'(mem_req_valid), 1);
      chk("t1_c3_count", 64'(ib_count), 4); chk("t1_c3_pc0", 64'(ib_pc[0]), 32'h10);
      repeat (6) tick();

      // one word per cycle: FIFO fills and credit runs out
      start(1, 1);
      tick(); tick(); @(negedge clock);
      chk("t2_c2_count", 64'(ib_count), 1); chk("t2_c2_pc0", 64'(ib_pc[0]), 0);
      tick(); @(negedge clock);
      chk("t2_c3_count", 64'(ib_count), 1); chk("t2_c3_pc0", 64'(ib_pc[0]), 32'h4);
      chk("t2_c3_valid", 64'(mem_req_valid), 0);
      tick(); @(negedge clock); chk("t2_c4_pc0", 64'(ib_pc[0]), 32'h8);
      tick(); @(negedge clock); chk("t2_c5_pc0", 64'(ib_pc[0]), 32'hC); chk("t2_c5_valid", 64'(mem_req_valid), 0);
      tick(); @(negedge clock);
      chk("t2_c6_valid", 64'(mem_req_valid), 1); chk("t2_c6_addr", 64'(mem_req_addr), 32'h20);
      chk("t2_c6_pc0", 64'(ib_pc[0]), 32'h10);
      repeat (8) tick();

      // three spots: no merge across entries
      start(3, 1);
      tick(); tick(); @(negedge clock);
      chk("t3_c2_count", 64'(ib_count), 3); chk("t3_c2_pc2", 64'(ib_pc[2]), 32'h8); chk("t3_c2_pc3", 64'(ib_pc[3]), 0);
      tick(); @(negedge clock);
      chk("t3_c3_count", 64'(ib_count), 1); chk("t3_c3_pc0", 64'(ib_pc[0]), 32'hC); chk("t3_c3_pc1", 64'(ib_pc[1]), 0);
      tick(); @(negedge clock);
      chk("t3_c4_count", 64'(ib_count), 3); chk("t3_c4_pc0", 64'(ib_pc[0]), 32'h10);
      repeat (6) tick();

      // redirect with two slow requests in flight
      start(4, 3);
      tick(); tick();
      restore_valid = 1; PC_restore = 32'h400;
      @(negedge clock); chk("t4_rst_valid", 64'(mem_req_valid), 0); chk("t4_rst_count", 64'(ib_count), 0);
      tick(); restore_valid = 0;
      @(negedge clock); chk("t4_c3_count", 64'(ib_count), 0); chk("t4_c3_valid", 64'(mem_req_valid), 0);
      tick(); @(negedge clock);
      chk("t4_c4_valid", 64'(mem_req_valid), 1); chk("t4_c4_addr", 64'(mem_req_addr), 32'h400);
      chk("t4_c4_count", 64'(ib_count), 0);
      tick(); tick(); tick(); tick(); @(negedge clock);
      chk("t4_c8_count", 64'(ib_count), 4); chk("t4_c8_pc0", 64'(ib_pc[0]), 32'h400);
      repeat (6) tick();

      // redirect in the same cycle as the only outstanding beat
      start(4, 2);
      tick(); mem_req_ready = 0;
      tick(); restore_valid = 1; PC_restore = 32'h800;
      @(negedge clock); chk("t5_rst_count", 64'(ib_count), 0); chk("t5_rst_valid", 64'(mem_req_valid), 0);
      tick(); restore_valid = 0; mem_req_ready = 1;
      @(negedge clock); chk("t5_c3_valid", 64'(mem_req_valid), 1); chk("t5_c3_addr", 64'(mem_req_addr), 32'h800);
      tick(); tick(); tick(); @(negedge clock);
      chk("t5_c6_count", 64'(ib_count), 4); chk("t5_c6_pc0", 64'(ib_pc[0]), 32'h800);
      repeat (6) tick();

      // asynchronous reset in the middle of a transfer
      start(0, 1);
      tick(); tick(); ib_spots = NW'(4);
      tick(); #1;
      chk("t6_pre_valid", 64'(mem_req_valid), 1); chk("t6_pre_addr", 64'(mem_req_addr), 32'h20);
      chk("t6_pre_count", 64'(ib_count), 4);
      reset = 0; #1;
      chk("t6_rst_valid", 64'(mem_req_valid), 0); chk("t6_rst_count", 64'(ib_count), 0);
      chk("t6_rst_addr", 64'(mem_req_addr), 0); chk("t6_rst_pc0", 64'(ib_pc[0]), 0);
      tick(); reset = 1;
      @(negedge clock); chk("t6_c0_valid", 64'(mem_req_valid), 1); chk("t6_c0_addr", 64'(mem_req_addr), 0);
      tick(); tick(); @(negedge clock);
      chk("t6_c2_count", 64'(ib_count), 4); chk("t6_c2_pc0", 64'(ib_pc[0]), 0);

      // stop issuing and let everything in flight drain
      repeat (4) tick();
      mem_req_ready = 0;
      repeat (10) tick();
      @(negedge clock);
      chk("sb_drained", 64'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
